sd_controller: RTL and testbench
================================

// Module: sd_controller
// PURPOSE
//  SD-card command-line controller for the CPU side of the FPGA. The CPU writes
//  a 32-bit argument and a 6-bit command index through a small register window.
//  The block builds the 48-bit SD command frame, appends CRC7 and shifts the
//  frame out on the CMD line, MSB first. It then captures the card's 48-bit
//  response. The data line is idle in this revision.
// PARAMETERS
//  RESP_TIMEOUT  64  clk cycles to wait for a response start bit before abandoning
// PORTS
//  clk        in   1  sole clock (SD clock rate); all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  addr       in   4  register index for CPU writes
//  data       in   8  CPU write data
//  cs         in   1  write strobe; sampled on posedge clk
//  i_sd_cmd   in   1  SD CMD line input (card response)
//  o_sd_cmd   out  1  SD CMD line output
//  i_sd_data  in   1  SD DAT0 input (unused; no functional effect)
//  o_sd_dat   out  1  SD DAT0 output, constant 1
// BEHAVIOUR
//  Reset: state.macro=IDLE, state.count=0, arg=0, cmd=0, resp=0; o_sd_cmd=1, o_sd_dat=1.
//  Registers (write-only; a write occurs on the posedge with cs=1):
//   0..3  arg[7:0], arg[15:8], arg[23:16], arg[31:24]
//   4     cmd index = data[5:0], data[7:6] ignored; in IDLE also starts a transfer
//   5..15 ignored
//  Frame latched at start: {1'b0, 1'b1, cmd[5:0], arg[31:0], crc7[6:0], 1'b1}.
//   crc7 is over the first 40 bits, poly x^7+x^3+1, init 0.
//  State record `state` has fields macro (enum IDLE, TXCMD, RXRESP) and count (6 bit).
//   The enum value TXCMD must be referenceable as dut.TXCMD.
//  IDLE: o_sd_cmd=1. Write to reg 4 -> on the same edge, latch frame, count<=0,
//   macro<=TXCMD.
//  TXCMD: o_sd_cmd = frame[47-count], combinational from count.
//   count increments each posedge.
//   On the edge where count==47: count<=0, macro<=RXRESP.
//   The full frame is thus 48 cycles, count 0..47.
//  RXRESP: o_sd_cmd=1.
//   Wait for i_sd_cmd==0 as the start bit, then shift 48 bits, start bit
//   included, into resp[47:0], then go to IDLE.
//   If no start bit arrives within RESP_TIMEOUT cycles, go to IDLE; resp is unchanged.
//  Writes to reg 4 outside IDLE are ignored (no restart).
//  Writes to regs 0..3 are always accepted. They affect only the next command,
//   because the frame is latched at start.
//  Reset mid-transfer: abort immediately to reset values; the line returns to 1.
//  A command can be issued back-to-back once IDLE is reached again.
// TESTING
//  CMD0, arg 0 -> frame 48'h400000000095 on o_sd_cmd, bit 47-count each cycle of TXCMD.
//  CMD8, arg 32'h000001AA -> frame 48'h48000001AA87.
//  CMD55, arg 0 -> frame 48'h770000000065.
//  CMD41, arg 32'h40180000 -> frame 48'h694018000019.
//   Run the four commands back-to-back with i_sd_cmd held at 1 (timeout path).
//  Reg-4 write during TXCMD -> ignored; current frame completes unchanged.
//   Drive a response 48'h080000 01AA13 on i_sd_cmd -> resp equals it, then IDLE.
//  Assert rst mid-TXCMD -> o_sd_cmd=1 and macro=IDLE asynchronously.
//   o_sd_dat stays 1 throughout all tests.

Source files
------------

// File: rtl/sd_controller.sv
`timescale 1ns/1ps
// SD CMD-line controller: CPU register window builds a 48-bit command frame
// with CRC7, shifts it out MSB first, then captures the card's 48-bit response.
module sd_controller #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] addr,
    input  logic [7:0] data,
    input  logic       cs,
    input  logic       i_sd_cmd,
    output logic       o_sd_cmd,
    input  logic       i_sd_data,
    output logic       o_sd_dat
);

    typedef enum logic [1:0] {IDLE, TXCMD, RXRESP} macro_t;

    typedef struct packed {
        macro_t     macro;
        logic [5:0] count;
    } state_t;

    localparam logic [5:0] TMO_LAST = 6'(RESP_TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    logic        rx_busy;
    logic        rx_busy_n;
    logic        start;
    logic        shift;
    logic [31:0] arg;
    logic [5:0]  cmd;
    logic [47:0] frame;
    logic [47:0] resp;
    logic [39:0] head;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign head = {2'b01, data[5:0], arg};

    always_comb begin
        state_n   = state;
        rx_busy_n = rx_busy;
        start     = 1'b0;
        shift     = 1'b0;
        unique case (state.macro)
            IDLE: begin
                if (cs && addr == 4'd4) begin
                    start         = 1'b1;
                    state_n.macro = TXCMD;
                    state_n.count = '0;
                end
            end
            TXCMD: begin
                if (state.count == 6'd47) begin
                    state_n.macro = RXRESP;
                    state_n.count = '0;
                    rx_busy_n     = 1'b0;
                end else begin
                    state_n.count = state.count + 6'd1;
                end
            end
            RXRESP: begin
                // count doubles as timeout counter, then as bit counter
                if (rx_busy) begin
                    shift = 1'b1;
                    if (state.count == 6'd47) begin
                        state_n.macro = IDLE;
                        state_n.count = '0;
                        rx_busy_n     = 1'b0;
                    end else begin
                        state_n.count = state.count + 6'd1;
                    end
                end else if (!i_sd_cmd) begin
                    shift         = 1'b1;
                    rx_busy_n     = 1'b1;
                    state_n.count = 6'd1;
                end else if (state.count == TMO_LAST) begin
                    state_n.macro = IDLE;
                    state_n.count = '0;
                end else begin
                    state_n.count = state.count + 6'd1;
                end
            end
            default: begin
                state_n.macro = IDLE;
                state_n.count = '0;
                rx_busy_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state.macro <= IDLE;
            state.count <= '0;
            rx_busy     <= 1'b0;
        end else begin
            state   <= state_n;
            rx_busy <= rx_busy_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg   <= '0;
            cmd   <= '0;
            frame <= '0;
            resp  <= '0;
        end else begin
            if (cs) begin
                case (addr)
                    4'd0: arg[7:0]   <= data;
                    4'd1: arg[15:8]  <= data;
                    4'd2: arg[23:16] <= data;
                    4'd3: arg[31:24] <= data;
                    4'd4: if (state.macro == IDLE) cmd <= data[5:0];
                    default: ;
                endcase
            end
            if (start) frame <= {head, crc7(head), 1'b1};
            if (shift) resp <= {resp[46:0], i_sd_cmd};
        end
    end

    assign o_sd_cmd = (state.macro == TXCMD) ? frame[6'd47 - state.count] : 1'b1;
    // DAT0 is idle in this revision
    assign o_sd_dat = i_sd_data | 1'b1;

endmodule

// File: tb/tb_sd_controller.sv
`timescale 1ns/1ps
// Randomized bench for sd_controller: frames and responses are checked
// against a polynomial-division CRC model and a register/response model.
module tb_sd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] data = '0;
    logic       cs = 1'b0;
    logic       i_sd_cmd = 1'b1;
    logic       i_sd_data = 1'b0;
    logic       o_sd_cmd;
    logic       o_sd_dat;

    int checks = 0;
    int failures = 0;

    logic [31:0] arg_m = '0;
    logic [47:0] resp_m = '0;

    sd_controller #(.RESP_TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data(data),
        .cs(cs),
        .i_sd_cmd(i_sd_cmd),
        .o_sd_cmd(o_sd_cmd),
        .i_sd_data(i_sd_data),
        .o_sd_dat(o_sd_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // CRC7 as remainder of (header * x^7) mod (x^7 + x^3 + 1)
    function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
        logic [39:0] h;
        logic [46:0] r;
        h = {2'b01, c, a};
        r = {h, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return {h, r[6:0], 1'b1};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        data = d;
        cs   = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        if (a < 4'd4) arg_m[a*8 +: 8] = d;
    endtask

    task automatic set_arg(input logic [31:0] a);
        for (int i = 0; i < 4; i++) wr(4'(i), a[i*8 +: 8]);
    endtask

    task automatic run_cmd(input logic [5:0] c, input logic [47:0] exp_frame,
                           input bit inject, input bit respond,
                           input logic [47:0] r, input int dly);
        logic [47:0] got;
        int          n;
        bit          line_ok;
        wr(4'd4, {2'($urandom), c});
        chk("start_tx", 64'(dut.state.macro), 64'(dut.TXCMD));
        for (int i = 0; i < 48; i++) begin
            got[47-i] = o_sd_cmd;
            if (inject && i == 8) begin
                addr = 4'd4;
                data = 8'($urandom);
                cs   = 1'b1;
            end else if (inject && i == 20) begin
                addr = 4'd1;
                data = 8'($urandom);
                cs   = 1'b1;
                arg_m[15:8] = data;
            end else begin
                cs = 1'b0;
            end
            @(negedge clk);
        end
        cs = 1'b0;
        chk("frame", 64'(got), 64'(exp_frame));
        chk("to_rx", 64'(dut.state.macro), 64'(dut.RXRESP));
        if (respond) begin
            repeat (dly) @(negedge clk);
            for (int j = 0; j < 48; j++) begin
                i_sd_cmd = r[47-j];
                @(negedge clk);
            end
            i_sd_cmd = 1'b1;
            resp_m   = r;
            chk("rx_idle", 64'(dut.state.macro), 64'(dut.IDLE));
        end else begin
            n       = 0;
            line_ok = 1'b1;
            while (dut.state.macro == dut.RXRESP && n < 200) begin
                if (o_sd_cmd !== 1'b1) line_ok = 1'b0;
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", 64'(n), 64'd64);
            chk("rx_line_high", 64'(line_ok), 64'd1);
        end
        chk("resp", 64'(dut.resp), 64'(resp_m));
        chk("dat_high", 64'(o_sd_dat), 64'd1);
        chk("idle_line", 64'(o_sd_cmd), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  c;
        logic [47:0] r;
        repeat (2) @(negedge clk);
        chk("rst_cmd", 64'(o_sd_cmd), 64'd1);
        chk("rst_dat", 64'(o_sd_dat), 64'd1);
        chk("rst_macro", 64'(dut.state.macro), 64'(dut.IDLE));
        chk("rst_count", 64'(dut.state.count), 64'd0);
        chk("rst_resp", 64'(dut.resp), 64'd0);
        rst = 1'b0;

        set_arg(32'h0);
        run_cmd(6'd0, 48'h400000000095, 1'b0, 1'b0, '0, 0);
        set_arg(32'h000001AA);
        run_cmd(6'd8, 48'h48000001AA87, 1'b0, 1'b0, '0, 0);
        set_arg(32'h0);
        run_cmd(6'd55, 48'h770000000065, 1'b0, 1'b0, '0, 0);
        set_arg(32'h40180000);
        run_cmd(6'd41, 48'h694018000019, 1'b0, 1'b0, '0, 0);

        set_arg(32'h000001AA);
        run_cmd(6'd8, 48'h48000001AA87, 1'b1, 1'b1, 48'h08000001AA13, 5);

        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(1, 0) == 1) set_arg($urandom);
            else wr(4'($urandom_range(3, 0)), 8'($urandom));
            wr(4'($urandom_range(15, 5)), 8'($urandom));
            c = 6'($urandom);
            r = {1'b0, 15'($urandom), 32'($urandom)};
            run_cmd(c, ref_frame(c, arg_m), bit'($urandom_range(1, 0)),
                    bit'($urandom_range(1, 0)), r, int'($urandom_range(40, 0)));
        end

        set_arg(32'h0);
        wr(4'd4, 8'd0);
        repeat (20) @(negedge clk);
        chk("mid_tx_line", 64'(o_sd_cmd), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_line", 64'(o_sd_cmd), 64'd1);
        chk("async_rst_macro", 64'(dut.state.macro), 64'(dut.IDLE));
        chk("async_rst_resp", 64'(dut.resp), 64'd0);
        arg_m  = '0;
        resp_m = '0;
        @(negedge clk);
        rst = 1'b0;
        run_cmd(6'd55, 48'h770000000065, 1'b0, 1'b1, 48'h370000012000 & 48'h7FFFFFFFFFFF, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
